spm_dump_tx: RTL and testbench

//   Debug readback engine, the opposite direction to memory preload: reads N words from the

---
 rtl/spm_dump_tx_pkg.sv | 22 ++
 rtl/uart_tx_core.sv | 63 ++++++
 rtl/spm_dump_tx.sv | 179 +++++++++++++++++
 tb/tb_spm_dump_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_dump_tx_pkg.sv
// Shared definitions for the SPM dump engine and its UART transmitter.
//   - state_e: 3-bit FSM encodings IDLE..FIN
//   - UART_START_BIT / UART_STOP_BIT line levels, BYTE_W byte width
//   - HIGH / LOW levels used for control flags
package spm_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3,
    ST_CHKSUM = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic HIGH           = 1'b1;
  localparam logic LOW            = 1'b0;
  localparam int   BYTE_W         = 8;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each bit
// CLK_DIV clock cycles long.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (line forced idle high)
//   tx_start  request to send tx_data; taken when tx_busy is low
//   tx_data   byte to send
//   tx_busy   core cannot take a byte this cycle; drops during the last cycle
//             of the stop bit so a waiting byte follows with no idle gap
//   uart_tx   serial line, idle high
module uart_tx_core
  import spm_dump_tx_pkg::*;
#(
  parameter int CLK_DIV = 87
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              uart_tx
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic              active_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        bits_left_q;   // bits still to shift out after the current one
  logic [BYTE_W:0]   frame_q;       // remaining data bits plus stop bit
  logic              uart_tx_q;
  logic              frame_end;

  assign frame_end = (div_q == '0) && (bits_left_q == '0);
  assign tx_busy   = active_q & ~frame_end;
  assign uart_tx   = uart_tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q    <= LOW;
      div_q       <= '0;
      bits_left_q <= '0;
      frame_q     <= '1;
      uart_tx_q   <= UART_STOP_BIT;
    end else if (tx_start && !tx_busy) begin
      active_q    <= HIGH;
      uart_tx_q   <= UART_START_BIT;
      frame_q     <= {UART_STOP_BIT, tx_data};
      bits_left_q <= 4'd9;
      div_q       <= DIV_W'(CLK_DIV - 1);
    end else if (active_q) begin
      if (div_q != '0) begin
        div_q <= div_q - 1'b1;
      end else if (bits_left_q != '0) begin
        uart_tx_q   <= frame_q[0];
        frame_q     <= {UART_STOP_BIT, frame_q[BYTE_W:1]};
        bits_left_q <= bits_left_q - 1'b1;
        div_q       <= DIV_W'(CLK_DIV - 1);
      end else begin
        active_q <= LOW;   // stop bit finished, line stays high
      end
    end
  end

endmodule

// File: rtl/spm_dump_tx.sv
// Debug readback engine: on a start pulse reads word_cnt words from the SPM
// starting at base_addr (address wraps modulo 2^ADDR_W) and sends each word
// MSB byte first over a UART line.
// Build option: define SPM_DUMP_CHECKSUM_EN to append one byte holding the XOR
// of all data bytes of the run. Without it no trailing byte is sent.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (aborts a run)
//   start        1-cycle pulse, accepted only while busy is low
//   base_addr    first word address, sampled with start
//   word_cnt     number of words, sampled with start (0 = no output)
//   mem_rd_en    SPM read enable, mem_addr read address
//   mem_rd_data  SPM read data, valid one cycle after mem_rd_en
//   uart_tx      serial output, idle high
//   busy         run in progress, done 1-cycle completion pulse
module spm_dump_tx
  import spm_dump_tx_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 87
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int BC_W   = $clog2(NBYTES + 1);
  localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q;
  logic              busy_q, done_q, mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] cur_addr_q;     // next address to read
  logic [ADDR_W:0]   remaining_q;    // words not yet fully handed to the TX core
  logic [DATA_W-1:0] word_q;         // unsent bytes, next byte in the top position
  logic [BC_W-1:0]   bytes_left_q;
`ifdef SPM_DUMP_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_q;
`endif

  logic              tx_start_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic              tx_busy;
  logic              tx_accept;
  logic              word_last;
  logic              word_done;

  // The first byte of a word goes straight from the read data in WAIT, which
  // puts the first start bit 3 cycles after the start pulse.
  always_comb begin
    tx_start_d = LOW;
    tx_data_d  = word_q[DATA_W-1 -: BYTE_W];
    case (state_q)
      ST_WAIT: begin
        tx_start_d = HIGH;
        tx_data_d  = mem_rd_data[DATA_W-1 -: BYTE_W];
      end
      ST_SEND: tx_start_d = HIGH;
`ifdef SPM_DUMP_CHECKSUM_EN
      ST_CHKSUM: begin
        tx_start_d = HIGH;
        tx_data_d  = chk_q;
      end
`endif
      default: ;
    endcase
  end

  assign tx_accept = tx_start_d & ~tx_busy;
  assign word_last = (state_q == ST_SEND) ? (bytes_left_q == BC_W'(1)) : (NBYTES == 1);
  assign word_done = tx_accept & word_last & ((state_q == ST_WAIT) | (state_q == ST_SEND));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= LOW;
      done_q       <= LOW;
      mem_rd_en_q  <= LOW;
      mem_addr_q   <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      word_q       <= '0;
      bytes_left_q <= '0;
`ifdef SPM_DUMP_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      done_q      <= LOW;
      mem_rd_en_q <= LOW;
`ifdef SPM_DUMP_CHECKSUM_EN
      if (tx_accept && state_q != ST_CHKSUM) chk_q <= chk_q ^ tx_data_d;
`endif
      case (state_q)
        ST_IDLE: if (start) begin
          busy_q      <= HIGH;
          remaining_q <= word_cnt;
`ifdef SPM_DUMP_CHECKSUM_EN
          chk_q       <= '0;
`endif
          if (word_cnt == '0) begin
            state_q <= ST_FIN;
          end else begin
            state_q     <= ST_READ;
            mem_rd_en_q <= HIGH;
            mem_addr_q  <= base_addr;
            cur_addr_q  <= base_addr + 1'b1;
          end
        end
        ST_READ: state_q <= ST_WAIT;
        ST_WAIT: begin
          state_q <= ST_SEND;
          if (tx_accept) begin
            word_q       <= mem_rd_data << BYTE_W;
            bytes_left_q <= BC_W'(NBYTES - 1);
          end else begin
            word_q       <= mem_rd_data;
            bytes_left_q <= BC_W'(NBYTES);
          end
        end
        ST_SEND: if (tx_accept) begin
          word_q       <= word_q << BYTE_W;
          bytes_left_q <= bytes_left_q - 1'b1;
        end
`ifdef SPM_DUMP_CHECKSUM_EN
        ST_CHKSUM: if (tx_accept) state_q <= ST_FIN;
`endif
        // Completion waits until the last frame has left the line.
        ST_FIN: if (!tx_busy) begin
          state_q <= ST_IDLE;
          busy_q  <= LOW;
          done_q  <= HIGH;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Last byte of a word handed over: fetch the next word or wrap up.
      if (word_done) begin
        remaining_q <= remaining_q - 1'b1;
        if (remaining_q != ONE_WORD) begin
          state_q     <= ST_READ;
          mem_rd_en_q <= HIGH;
          mem_addr_q  <= cur_addr_q;
          cur_addr_q  <= cur_addr_q + 1'b1;
        end else begin
`ifdef SPM_DUMP_CHECKSUM_EN
          state_q <= ST_CHKSUM;
`else
          state_q <= ST_FIN;
`endif
        end
      end
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  uart_tx_core #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start_d),
    .tx_data (tx_data_d),
    .tx_busy (tx_busy),
    .uart_tx (uart_tx)
  );

endmodule

// File: tb/tb_spm_dump_tx.sv
module tb_spm_dump_tx;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 32;
  localparam int CLK_DIV = 87;
  localparam int FRAME   = 10 * CLK_DIV;

  typedef struct {
    logic [7:0] data;
    int         fall_cyc;
  } exp_t;

  logic              clk, rst, start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_cnt;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              uart_tx, busy, done;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int cyc = 0;
  int rst_epoch = 0;
  int checks = 0;
  int errors = 0;

  exp_t              exp_byte_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_done_q[$];

  spm_dump_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SPM port B model: data valid only in the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    else           mem_rd_data <= 32'hDEAD_BEEF;
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Issue a start pulse and queue the expected bytes, reads and done time.
  task automatic start_run(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
    int s, nb;
    logic [7:0] chk;
    @(negedge clk);
    base_addr = base;
    word_cnt  = cnt;
    start     = 1'b1;
    s   = cyc;
    nb  = 0;
    chk = 8'h00;
    for (int w = 0; w < int'(cnt); w++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = base + ADDR_W'(w);
      d = mem[a];
      exp_addr_q.push_back(a);
      for (int b = 3; b >= 0; b--) begin
        exp_t e;
        e.data     = d[8*b +: 8];
        e.fall_cyc = s + 3 + FRAME * nb;
        exp_byte_q.push_back(e);
        chk = chk ^ e.data;
        nb++;
      end
    end
`ifdef SPM_DUMP_CHECKSUM_EN
    if (cnt != '0) begin
      exp_t e;
      e.data     = chk;
      e.fall_cyc = s + 3 + FRAME * nb;
      exp_byte_q.push_back(e);
      nb++;
    end
`endif
    exp_done_q.push_back((nb == 0) ? s + 2 : s + 3 + FRAME * nb);
    $display("start base=%03h cnt=%0d at cycle %0d", base, cnt, s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: done not seen, got none within %0d cycles, required one", name, budget);
    end
  endtask

  // Sample one frame at bit centres; abort if a reset intervenes.
  task automatic get_frame(input int ep, output logic ab, output logic [9:0] raw);
    raw = '1;
    ab  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < ((k == 0) ? CLK_DIV / 2 : CLK_DIV); c++) begin
        if (!ab) begin
          @(negedge clk);
          if (rst || ep != rst_epoch) ab = 1'b1;
        end
      end
      if (!ab) raw[k] = uart_tx;
    end
  endtask

  task automatic uart_monitor();
    logic prev, ab;
    logic [9:0] raw;
    int fc;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !uart_tx) begin
        fc = cyc;
        get_frame(rst_epoch, ab, raw);
        if (!ab) begin
          $display("byte %02h frame start cycle %0d", raw[8:1], fc);
          if (exp_byte_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL uart_byte: got unexpected frame %02h, required no output", raw[8:1]);
          end else begin
            e = exp_byte_q.pop_front();
            check_val("uart_frame", {22'd0, raw}, {22'd0, 1'b1, e.data, 1'b0});
            check_val("uart_fall_cycle", fc, e.fall_cyc);
          end
        end
      end
      prev = uart_tx;
    end
  endtask

  task automatic port_monitor();
    logic [ADDR_W-1:0] a;
    int dc;
    forever begin
      @(negedge clk);
      if (!rst && mem_rd_en) begin
        $display("read addr %03h at cycle %0d", mem_addr, cyc);
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_en: got unexpected read of %03h, required none", mem_addr);
        end else begin
          a = exp_addr_q.pop_front();
          check_val("rd_addr", mem_addr, a);
        end
      end
      if (!rst && done) begin
        $display("done at cycle %0d", cyc);
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done: got unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          dc = exp_done_q.pop_front();
          check_val("done_cycle", cyc, dc);
          check_val("busy_at_done", busy, 0);
        end
      end
    end
  endtask

  initial begin
    int s;
    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_cnt = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[11'h010] = 32'h1234_5678;
    mem[11'h7FE] = 32'hA1B2_C3D4;
    mem[11'h7FF] = 32'h55AA_00FF;
    mem[11'h000] = 32'h8001_7F10;
    mem[11'h100] = 32'hCAFE_F00D;
    mem[11'h101] = 32'h0BAD_BEEF;
    mem[11'h020] = 32'h3C5A_9612;
    mem[11'h021] = 32'h6E0F_A5C3;
    mem[11'h040] = 32'h0102_0304;
    mem[11'h041] = 32'hFF00_0000;

    fork
      uart_monitor();
      port_monitor();
    join_none

    // Reset values
    #1 rst = 1'b1;
    rst_epoch++;
    repeat (3) @(negedge clk);
    check_val("rst_uart_tx", uart_tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_mem_rd_en", mem_rd_en, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: single word, bytes 12 34 56 78
    start_run(11'h010, 12'd1);
    wait_done(FRAME * 6, "t1_done");
    repeat (5) @(negedge clk);

    // 2: address wrap 7FE, 7FF, 000
    start_run(11'h7FE, 12'd3);
    wait_done(FRAME * 14, "t2_done");
    repeat (5) @(negedge clk);

    // 3: zero words
    start_run(11'h055, 12'd0);
    check_val("t3_busy", busy, 1);
    check_val("t3_done_early", done, 0);
    wait_done(10, "t3_done");
    check_val("t3_uart_idle", uart_tx, 1);
    repeat (5) @(negedge clk);

    // 4: start pulse while busy is ignored
    start_run(11'h100, 12'd2);
    repeat (1000) @(negedge clk);
    check_val("t4_busy", busy, 1);
    base_addr = 11'h300;
    word_cnt  = 12'd5;
    start     = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(FRAME * 10, "t4_done");
    repeat (5) @(negedge clk);

    // 5: reset during the data bits of byte 2, then a normal run
    start_run(11'h020, 12'd2);
    s = exp_done_q[0] - 3 - FRAME * (exp_byte_q.size());
    while (cyc < s + 3 + FRAME + 300) @(negedge clk);
    #2 rst = 1'b1;
    rst_epoch++;
    #1;
    check_val("t5_rst_uart_tx", uart_tx, 1);
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_mem_rd_en", mem_rd_en, 0);
    exp_byte_q.delete();
    exp_addr_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_run(11'h021, 12'd1);
    wait_done(FRAME * 6, "t5_restart_done");
    repeat (5) @(negedge clk);

    // 6: 01020304, FF000000 (checksum FB when enabled)
    start_run(11'h040, 12'd2);
    wait_done(FRAME * 11, "t6_done");
    repeat (20) @(negedge clk);

    check_val("pending_bytes", exp_byte_q.size(), 0);
    check_val("pending_reads", exp_addr_q.size(), 0);
    check_val("pending_done", exp_done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
